dispensador: RTL

Downstream actuator controller of the vending machine: consumes the comparator's LP (liberar produto) and DM (devolver moedas) decisions plus the accumulated coin value. It drives the product motor and the coin-eject solenoid with timed pulses, confirms each action against a drop sensor, and returns change one unit coin at a time. It reports completion to the end-of-sale logic and latches a fault on sensor timeout.

---
 rtl/vendas_pkg.sv | 37 +++
 rtl/dispensador_if.sv | 30 +++
 rtl/temporizador_ciclos.sv | 37 +++
 rtl/dispensador.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/vendas_pkg.sv
// Shared types and helpers for the vending-machine actuator controller.
//   estado_e : dispenser FSM states
//   CreditW  : width of credit / change counts (unit coins)
//   PriceW   : width of product price (unit coins)
//   max3     : largest of three cycle counts, used to size the shared timer
//   sub_sat  : unsigned subtract that clamps at zero instead of wrapping
package vendas_pkg;

  localparam int unsigned CreditW = 4;
  localparam int unsigned PriceW  = 3;

  typedef enum logic [2:0] {
    OCIOSO,
    MOTOR,
    ESPERA_PROD,
    EJETA,
    ESPERA_MOEDA,
    FIM,
    FALHA
  } estado_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One extra bit catches the borrow; a borrow means the result would be negative.
  function automatic logic [CreditW-1:0] sub_sat(input logic [CreditW-1:0] a,
                                                 input logic [CreditW-1:0] b);
    logic [CreditW:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[CreditW] ? '0 : diff[CreditW-1:0];
  endfunction

endpackage

// File: rtl/dispensador_if.sv
// Bundle of the dispenser's decision, sensor and actuator signals.
//   master : upstream logic / sensors (drives LP, DM, values, sensors)
//   slave  : dispenser (drives motor, ejetar, ocupado, concluido, falha, restante)
interface dispensador_if;
  import vendas_pkg::*;

  logic               LP;
  logic               DM;
  logic [CreditW-1:0] valorMoedas;
  logic [PriceW-1:0]  valorProduto;
  logic               produto_caiu;
  logic               moeda_saiu;
  logic               motor;
  logic               ejetar;
  logic               ocupado;
  logic               concluido;
  logic               falha;
  logic [CreditW-1:0] restante;

  modport master (
    output LP, DM, valorMoedas, valorProduto, produto_caiu, moeda_saiu,
    input  motor, ejetar, ocupado, concluido, falha, restante
  );

  modport slave (
    input  LP, DM, valorMoedas, valorProduto, produto_caiu, moeda_saiu,
    output motor, ejetar, ocupado, concluido, falha, restante
  );

endinterface

// File: rtl/temporizador_ciclos.sv
// Loadable down-counter that stops at zero.
//   clk, reset : clock, asynchronous active-high reset
//   load_i     : load valor_i this cycle (has priority over counting)
//   valor_i    : value to load; done_o rises valor_i cycles after the load
//   done_o     : counter is at zero
module temporizador_ciclos #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] valor_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = valor_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/dispensador.sv
// Product / change dispenser controller.
//   clk, reset : clock, asynchronous active-high reset
//   disp_io    : slave side of dispensador_if
//     LP / DM             release product / refund, acted on rising edge in OCIOSO
//     valorMoedas         credit in unit coins; valorProduto price in unit coins
//     produto_caiu        product drop sensor, sampled only in ESPERA_PROD
//     moeda_saiu          coin exit sensor, sampled only in ESPERA_MOEDA
//     motor / ejetar      timed drive pulses
//     ocupado             state is not OCIOSO
//     concluido           one-cycle pulse on clean completion
//     falha               sticky sensor-timeout fault
//     restante            coins still to eject
module dispensador
  import vendas_pkg::*;
#(
  parameter int unsigned MOTOR_CICLOS   = 25_000_000,
  parameter int unsigned EJETAR_CICLOS  = 5_000_000,
  parameter int unsigned TIMEOUT_CICLOS = 50_000_000
) (
  input logic          clk,
  input logic          reset,
  dispensador_if.slave disp_io
);

  localparam int unsigned MaxCiclos = max3(MOTOR_CICLOS, EJETAR_CICLOS, TIMEOUT_CICLOS);
  // Timer holds at most MaxCiclos-1.
  localparam int unsigned CntW = (MaxCiclos > 1) ? $clog2(MaxCiclos) : 1;

  localparam logic [CntW-1:0] MotorCarga   = CntW'(MOTOR_CICLOS - 1);
  localparam logic [CntW-1:0] EjetarCarga  = CntW'(EJETAR_CICLOS - 1);
  localparam logic [CntW-1:0] TimeoutCarga = CntW'(TIMEOUT_CICLOS - 1);

  estado_e            state_q, state_d;
  logic [CreditW-1:0] restante_q, restante_d;
  logic               lp_prev_q, dm_prev_q;
  logic               armed_q;
  logic               motor_q, ejetar_q, ocupado_q, concluido_q, falha_q;

  logic               lp_edge, dm_edge;
  logic               timer_load, timer_done;
  logic [CntW-1:0]    timer_valor;

  // The previous-value registers clear to 0 on reset, so they only become meaningful after
  // one sample; armed_q masks that first cycle so a level held through reset is not an edge.
  assign lp_edge = armed_q & disp_io.LP & ~lp_prev_q;
  assign dm_edge = armed_q & disp_io.DM & ~dm_prev_q;

  always_comb begin
    state_d    = state_q;
    restante_d = restante_q;
    unique case (state_q)
      OCIOSO: begin
        // Refund has priority over a simultaneous release.
        if (dm_edge) begin
          restante_d = disp_io.valorMoedas;
          state_d    = (disp_io.valorMoedas == '0) ? FIM : EJETA;
        end else if (lp_edge) begin
          restante_d = sub_sat(disp_io.valorMoedas, CreditW'(disp_io.valorProduto));
          state_d    = MOTOR;
        end
      end
      MOTOR: begin
        if (timer_done) state_d = ESPERA_PROD;
      end
      ESPERA_PROD: begin
        // Sensor beats a timeout in the same cycle.
        if (disp_io.produto_caiu) begin
          state_d = (restante_q != '0) ? EJETA : FIM;
        end else if (timer_done) begin
          state_d = FALHA;
        end
      end
      EJETA: begin
        if (timer_done) state_d = ESPERA_MOEDA;
      end
      ESPERA_MOEDA: begin
        if (disp_io.moeda_saiu) begin
          restante_d = sub_sat(restante_q, CreditW'(1));
          state_d    = (restante_d != '0) ? EJETA : FIM;
        end else if (timer_done) begin
          state_d = FALHA;
        end
      end
      FIM:     state_d = OCIOSO;
      FALHA:   state_d = FALHA;
      default: state_d = OCIOSO;
    endcase
  end

  // Pulses and waits never overlap, so one timer serves both; reload on every state entry.
  always_comb begin
    timer_load = (state_d != state_q);
    unique case (state_d)
      MOTOR:                     timer_valor = MotorCarga;
      EJETA:                     timer_valor = EjetarCarga;
      ESPERA_PROD, ESPERA_MOEDA: timer_valor = TimeoutCarga;
      default:                   timer_valor = '0;
    endcase
  end

  temporizador_ciclos #(
    .Width (CntW)
  ) u_temporizador (
    .clk     (clk),
    .reset   (reset),
    .load_i  (timer_load),
    .valor_i (timer_valor),
    .done_o  (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= OCIOSO;
      restante_q  <= '0;
      lp_prev_q   <= 1'b0;
      dm_prev_q   <= 1'b0;
      armed_q     <= 1'b0;
      motor_q     <= 1'b0;
      ejetar_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      falha_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      restante_q  <= restante_d;
      lp_prev_q   <= disp_io.LP;
      dm_prev_q   <= disp_io.DM;
      armed_q     <= 1'b1;
      // Outputs decoded from the next state so they change together with state_q.
      motor_q     <= (state_d == MOTOR);
      ejetar_q    <= (state_d == EJETA);
      ocupado_q   <= (state_d != OCIOSO);
      concluido_q <= (state_d == FIM);
      falha_q     <= (state_d == FALHA);
    end
  end

  assign disp_io.motor     = motor_q;
  assign disp_io.ejetar    = ejetar_q;
  assign disp_io.ocupado   = ocupado_q;
  assign disp_io.concluido = concluido_q;
  assign disp_io.falha     = falha_q;
  assign disp_io.restante  = restante_q;

endmodule
